spi_reg_controller: RTL and testbench
=====================================

# spi_reg_controller

Byte-level transaction controller that sits behind the SPI slave shifter, in the `clk` domain. It decodes a command byte, then sequences burst reads and writes into a small configuration register file, with address auto-increment. It drives the slave's transmit byte and exposes the registers to the ECG datapath. The SPI slave supplies received bytes and a chip-select already synchronised to `clk`.

## Interface
- `NUM_REGS`, 8: writable config registers. Range 1..126.
- `ID_VALUE`, 8'hA5: constant returned at address 0x00.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ss_n`  in  1  synchronised chip-select; low = transaction active.
- `rx_valid`  in  1  one-cycle pulse; `rx_data` holds a complete received byte.
- `rx_data`  in  8  received byte. Bit 0 is first on the wire.
- `status`  in  8  read-only status word from the datapath.
- `tx_data`  out  8  next byte for the slave to shift out.
- `tx_load`  out  1  one-cycle pulse; the slave latches `tx_data` for the next byte.
- `cfg_regs`  out  8*NUM_REGS  flattened config registers; register k is at bits [8k+7:8k].
- `wr_strobe`  out  1  one-cycle pulse when a config register is written.
- `wr_addr`  out  7  bus address of the last write, valid with `wr_strobe`.
- `abort`  out  1  one-cycle pulse when `ss_n` rises in CMD state, i.e. before any command byte.

## Operation
- Address map:
  - 0x00 = `ID_VALUE`, read-only.
  - 0x01 = `status`, read-only, sampled when loaded into `tx_data`.
  - 0x02..0x02+NUM_REGS-1 = config registers, read/write.
  - All other addresses read 0x00. Writes to them, or to 0x00/0x01, are ignored with no `wr_strobe`.
- Command byte: bit7 = 1 for read, 0 for write. Bits 6:0 = start address.
- FSM states and transitions:
  - IDLE -> CMD when `ss_n` is low.
  - CMD -> READ or WRITE on `rx_valid`, according to bit7.
  - READ, WRITE: each `rx_valid` processes one byte and increments the 7-bit address, wrapping 0x7F -> 0x00.
  - Any non-IDLE state -> IDLE on the cycle `ss_n` is sampled high.
- READ:
  - Command decode loads `tx_data` = contents of the start address.
  - Each later `rx_valid` loads the next address. The received byte is discarded.
- WRITE:
  - Each `rx_valid` writes `rx_data` to the current address, pulses `wr_strobe`/`wr_addr` if the address is writable, and loads `tx_data` = 0x00.
- Entering CMD (falling `ss_n`) loads `tx_data` = 0x00 with `tx_load`.
- Simultaneous `rx_valid` and `ss_n` high in the same cycle: the byte is processed first (write committed, strobe issued), then the FSM goes to IDLE. No `abort` in this case, even if the state was CMD.
- `abort` only when `ss_n` is sampled high in CMD with no `rx_valid` that cycle.
- Reset, including mid-transaction: FSM to IDLE, address 0, all config registers 0x00.
- An `rx_valid` arriving while in IDLE is ignored.

## Timing
- Reset values: `tx_data`=0x00, `tx_load`=0, `cfg_regs`=0, `wr_strobe`=0, `wr_addr`=0, `abort`=0.
- `rx_valid` at cycle N -> `tx_load`, `tx_data`, `wr_strobe`, `wr_addr` and the `cfg_regs` update all registered at N+1.
- `ss_n` falling sampled at N -> CMD and `tx_load` at N+1.
- `ss_n` high sampled at N -> IDLE at N+1; `abort` at N+1.
- Exactly one `tx_load` per processed `rx_valid`. No `tx_load` in IDLE.
- Minimum spacing between `rx_valid` pulses is 2 cycles. Back-to-back pulses are not supported.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `reset`=0 mid-burst -> all outputs 0, state IDLE. A following read of 0x02 returns 0x00.
- ID/status read: `ss_n` low, command 0x80, two dummy bytes, with `status`=0x3C -> `tx_data` sequence 0x00, 0xA5, 0x3C. One cycle after each `rx_valid`.
- Burst write then read: write command 0x02 with data 0x11, 0x22, 0x33 -> three `wr_strobe`s at addresses 2/3/4, `cfg_regs[23:0]`=0x332211. Read 0x82 returns 0x11, 0x22, 0x33.
- Read-only and wrap: write command 0x7F with 0x55, 0x66 -> no `wr_strobe`, address wraps to 0x00, ID still 0xA5.
- Abort: `ss_n` low then high with no byte -> one `abort` pulse, state IDLE, no register change.
- Simultaneous end: last write byte's `rx_valid` in the same cycle as `ss_n` high -> write committed with `wr_strobe`, no `abort`, IDLE next cycle.

Source files
------------

// File: rtl/spi_reg_controller.sv
// -----------------------------------------------------------------------------
// spi_reg_controller
//
// Byte-level transaction controller behind an SPI slave shifter. The first
// byte of a transaction is a command (bit7 = 1 read, 0 write; bits 6:0 =
// start address). The bytes that follow are burst reads or writes with 7-bit
// address auto-increment. Config registers are exported to the datapath.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   ss_n       in   chip-select synchronised to clk, low = transaction active
//   rx_valid   in   one-cycle pulse, rx_data holds a received byte
//   rx_data    in   received byte
//   status     in   read-only status word, readable at address 0x01
//   tx_data    out  next byte for the slave to shift out
//   tx_load    out  one-cycle pulse, slave latches tx_data
//   cfg_regs   out  flattened config registers, register k at [8k+7:8k]
//   wr_strobe  out  one-cycle pulse on a config register write
//   wr_addr    out  bus address of the last config write
//   abort      out  one-cycle pulse when ss_n rises before any command byte
// -----------------------------------------------------------------------------
module spi_reg_controller #(
   parameter int         NUM_REGS = 8,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ss_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic [7:0]            status,
   output logic [7:0]            tx_data,
   output logic                  tx_load,
   output logic [8*NUM_REGS-1:0] cfg_regs,
   output logic                  wr_strobe,
   output logic [6:0]            wr_addr,
   output logic                  abort
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t                state_q, state_d, proc_state_s;
   logic [6:0]            addr_q, addr_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_load_q, tx_load_d;
   logic [8*NUM_REGS-1:0] cfg_q, cfg_d;
   logic                  wr_strobe_q, wr_strobe_d;
   logic [6:0]            wr_addr_q, wr_addr_d;
   logic                  abort_q, abort_d;

   // True when the bus address maps onto one of the config registers.
   function automatic logic is_writable(input logic [6:0] a);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (a == 7'(k + 2)) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

   // Read mux over the address map; unmapped addresses read as zero.
   function automatic logic [7:0] read_byte(input logic [6:0]            a,
                                            input logic [7:0]            stat,
                                            input logic [8*NUM_REGS-1:0] regs);
      logic [7:0] r;
      r = 8'h00;
      if (a == 7'h00) begin
         r = ID_VALUE;
      end else if (a == 7'h01) begin
         r = stat;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (a == 7'(k + 2)) begin
               r = regs[8*k +: 8];
            end else begin
               r = r;
            end
         end
      end
      return r;
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      proc_state_s = state_q;
      addr_d       = addr_q;
      tx_data_d    = tx_data_q;
      tx_load_d    = 1'b0;
      cfg_d        = cfg_q;
      wr_strobe_d  = 1'b0;
      wr_addr_d    = wr_addr_q;
      abort_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // rx_valid is deliberately ignored here.
            if (!ss_n) begin
               proc_state_s = ST_CMD;
               tx_data_d    = 8'h00;
               tx_load_d    = 1'b1;
            end else begin
               proc_state_s = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (rx_valid) begin
               tx_load_d = 1'b1;
               if (rx_data[7]) begin
                  // Start byte goes out now, so the pointer moves past it.
                  proc_state_s = ST_READ;
                  tx_data_d    = read_byte(rx_data[6:0], status, cfg_q);
                  addr_d       = rx_data[6:0] + 7'd1;
               end else begin
                  proc_state_s = ST_WRITE;
                  tx_data_d    = 8'h00;
                  addr_d       = rx_data[6:0];
               end
            end else if (ss_n) begin
               abort_d = 1'b1;
            end else begin
               abort_d = 1'b0;
            end
         end
         ST_READ: begin
            if (rx_valid) begin
               tx_data_d = read_byte(addr_q, status, cfg_q);
               tx_load_d = 1'b1;
               addr_d    = addr_q + 7'd1;
            end else begin
               tx_load_d = 1'b0;
            end
         end
         ST_WRITE: begin
            if (rx_valid) begin
               for (int k = 0; k < NUM_REGS; k++) begin
                  if (addr_q == 7'(k + 2)) begin
                     cfg_d[8*k +: 8] = rx_data;
                  end else begin
                     cfg_d[8*k +: 8] = cfg_d[8*k +: 8];
                  end
               end
               if (is_writable(addr_q)) begin
                  wr_strobe_d = 1'b1;
                  wr_addr_d   = addr_q;
               end else begin
                  wr_strobe_d = 1'b0;
               end
               tx_data_d = 8'h00;
               tx_load_d = 1'b1;
               addr_d    = addr_q + 7'd1;
            end else begin
               tx_load_d = 1'b0;
            end
         end
         default: begin
            proc_state_s = ST_IDLE;
         end
      endcase

      // A byte arriving with ss_n high is processed above first; deselect
      // then wins the state transition.
      if ((state_q != ST_IDLE) && ss_n) begin
         state_d = ST_IDLE;
      end else begin
         state_d = proc_state_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= 7'd0;
         tx_data_q   <= 8'h00;
         tx_load_q   <= 1'b0;
         cfg_q       <= '0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 7'd0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tx_data_q   <= tx_data_d;
         tx_load_q   <= tx_load_d;
         cfg_q       <= cfg_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         abort_q     <= abort_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_load   = tx_load_q;
   assign cfg_regs  = cfg_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign abort     = abort_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_controller
//
// Directed bench for spi_reg_controller. A transaction-level model (active
// flag, command-seen flag, direction, pointer, register array) predicts every
// output each cycle; a compare process checks the DUT on each falling edge.
// Scenario checks against hand-computed literals pin the model itself.
// -----------------------------------------------------------------------------
module tb_spi_reg_controller;

   localparam int NR = 8;

   logic          clk      = 1'b0;
   logic          reset    = 1'b0;
   logic          ss_n     = 1'b1;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data  = 8'h00;
   logic [7:0]    status   = 8'h3C;
   logic [7:0]    tx_data;
   logic          tx_load;
   logic [8*NR-1:0] cfg_regs;
   logic          wr_strobe;
   logic [6:0]    wr_addr;
   logic          abort;

   spi_reg_controller #(.NUM_REGS(NR), .ID_VALUE(8'hA5)) dut (
      .clk       (clk),
      .reset     (reset),
      .ss_n      (ss_n),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .status    (status),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .cfg_regs  (cfg_regs),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_active;
   bit         m_have_cmd;
   bit         m_rd;
   logic [6:0] m_ptr;
   logic [7:0] m_regs [NR];
   int         m_idx;
   logic [7:0] exp_tx;
   bit         exp_load, exp_ws, exp_abort;
   logic [6:0] exp_wa;

   function automatic logic [7:0] peek(input logic [6:0] a);
      int i;
      i = int'(a) - 2;
      if (a == 7'd0)           return 8'hA5;
      else if (a == 7'd1)      return status;
      else if (i < NR)         return m_regs[i];
      else                     return 8'h00;
   endfunction

   function automatic logic [8*NR-1:0] model_cfg();
      logic [8*NR-1:0] v;
      for (int k = 0; k < NR; k++) v[8*k +: 8] = m_regs[k];
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_active = 0; m_have_cmd = 0; m_rd = 0; m_ptr = 7'd0;
            for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
            exp_tx = 8'h00; exp_load = 0; exp_ws = 0; exp_wa = 7'd0; exp_abort = 0;
         end else begin
            exp_load = 0; exp_ws = 0; exp_abort = 0;
            if (!m_active) begin
               if (!ss_n) begin
                  m_active = 1; m_have_cmd = 0;
                  exp_tx = 8'h00; exp_load = 1;
               end
            end else begin
               if (rx_valid) begin
                  exp_load = 1;
                  if (!m_have_cmd) begin
                     m_have_cmd = 1; m_rd = rx_data[7]; m_ptr = rx_data[6:0];
                     if (m_rd) begin exp_tx = peek(m_ptr); m_ptr = m_ptr + 7'd1; end
                     else exp_tx = 8'h00;
                  end else if (m_rd) begin
                     exp_tx = peek(m_ptr); m_ptr = m_ptr + 7'd1;
                  end else begin
                     m_idx = int'(m_ptr) - 2;
                     if (m_idx >= 0 && m_idx < NR) begin
                        m_regs[m_idx] = rx_data; exp_ws = 1; exp_wa = m_ptr;
                     end
                     exp_tx = 8'h00; m_ptr = m_ptr + 7'd1;
                  end
               end else if (ss_n && !m_have_cmd) begin
                  exp_abort = 1;
               end
               if (ss_n) m_active = 0;
            end
         end
      end
   end

   // ---------------- compare + logging on falling edge ----------------
   logic [7:0] tx_log [$];
   logic [6:0] ws_log [$];
   int         ab_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         check("tx_data",   64'(tx_data),   64'(exp_tx));
         check("tx_load",   64'(tx_load),   64'(exp_load));
         check("cfg_regs",  64'(cfg_regs),  64'(model_cfg()));
         check("wr_strobe", 64'(wr_strobe), 64'(exp_ws));
         check("wr_addr",   64'(wr_addr),   64'(exp_wa));
         check("abort",     64'(abort),     64'(exp_abort));
         if (tx_load)   tx_log.push_back(tx_data);
         if (wr_strobe) ws_log.push_back(wr_addr);
         if (abort)     ab_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic sel();
      @(posedge clk); #1 ss_n = 1'b0;
      cyc(2);
   endtask

   task automatic desel();
      @(posedge clk); #1 ss_n = 1'b1;
      cyc(2);
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
      @(posedge clk); #1 rx_valid = 1'b0;
      cyc(1);
   endtask

   task automatic send_last(input logic [7:0] b);
      @(posedge clk); #1 rx_valid = 1'b1; rx_data = b; ss_n = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
      cyc(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int tb0, wb0, ab0;
      cyc(3);
      reset = 1'b1;
      cyc(2);
      check("rst_tx_data", 64'(tx_data), 64'h0);
      check("rst_cfg",     64'(cfg_regs), 64'h0);

      // ID / status read
      tb0 = tx_log.size();
      sel(); send(8'h80); send(8'h00); send(8'h00); desel();
      check("id_cnt",  64'(tx_log.size() - tb0), 64'd4);
      check("id_ld0",  64'(tx_log[tb0]),     64'h00);
      check("id_ld1",  64'(tx_log[tb0 + 1]), 64'hA5);
      check("id_ld2",  64'(tx_log[tb0 + 2]), 64'h3C);

      // burst write then read back
      wb0 = ws_log.size();
      sel(); send(8'h02); send(8'h11); send(8'h22); send(8'h33); desel();
      check("bw_cnt",  64'(ws_log.size() - wb0), 64'd3);
      check("bw_a0",   64'(ws_log[wb0]),     64'd2);
      check("bw_a1",   64'(ws_log[wb0 + 1]), 64'd3);
      check("bw_a2",   64'(ws_log[wb0 + 2]), 64'd4);
      check("bw_cfg",  64'(cfg_regs[23:0]),  64'h332211);
      tb0 = tx_log.size();
      sel(); send(8'h82); send(8'h00); send(8'h00); desel();
      check("br_d0",   64'(tx_log[tb0 + 1]), 64'h11);
      check("br_d1",   64'(tx_log[tb0 + 2]), 64'h22);
      check("br_d2",   64'(tx_log[tb0 + 3]), 64'h33);

      // read-only targets and wrap 0x7F -> 0x00
      wb0 = ws_log.size();
      sel(); send(8'h7F); send(8'h55); send(8'h66); desel();
      check("ro_nostrobe", 64'(ws_log.size() - wb0), 64'd0);
      check("ro_cfg",      64'(cfg_regs[23:0]),      64'h332211);
      tb0 = tx_log.size();
      sel(); send(8'h80); desel();
      check("ro_id",   64'(tx_log[tb0 + 1]), 64'hA5);

      // abort with no byte
      ab0 = ab_cnt;
      sel(); desel();
      check("ab_cnt",  64'(ab_cnt - ab0), 64'd1);
      check("ab_cfg",  64'(cfg_regs[23:0]), 64'h332211);

      // last write byte coincides with deselect
      ab0 = ab_cnt; wb0 = ws_log.size();
      sel(); send(8'h05); send(8'hAB); send_last(8'hCD);
      check("se_cnt",  64'(ws_log.size() - wb0), 64'd2);
      check("se_a1",   64'(ws_log[wb0 + 1]),     64'd6);
      check("se_r3",   64'(cfg_regs[31:24]),     64'hAB);
      check("se_r4",   64'(cfg_regs[39:32]),     64'hCD);
      check("se_noab", 64'(ab_cnt - ab0),        64'd0);

      // command byte coincides with deselect: no abort
      ab0 = ab_cnt;
      sel(); send_last(8'h83);
      check("sc_noab", 64'(ab_cnt - ab0), 64'd0);

      // reset mid-burst
      sel(); send(8'h02); send(8'h77);
      @(posedge clk); #3 reset = 1'b0;
      #1;
      check("mr_tx",    64'(tx_data),   64'h0);
      check("mr_load",  64'(tx_load),   64'h0);
      check("mr_cfg",   64'(cfg_regs),  64'h0);
      check("mr_ws",    64'(wr_strobe), 64'h0);
      check("mr_wa",    64'(wr_addr),   64'h0);
      check("mr_abort", 64'(abort),     64'h0);
      ss_n = 1'b1;
      cyc(2);
      reset = 1'b1;
      cyc(2);
      tb0 = tx_log.size();
      sel(); send(8'h82); desel();
      check("mr_rd",   64'(tx_log[tb0 + 1]), 64'h00);

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
